uart_depacketizer: RTL and testbench

//   Receive end of the UART packetizer link. Oversamples serial_in, recovers
//   8N1 frames (start, 8 data LSB-first, 1 stop) and buffers the bytes in an

---
 rtl/uart_depacketizer.sv | 105 ++++++++++
 tb/tb_uart_depacketizer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_depacketizer.sv
// uart_depacketizer: 8N1 UART receiver with centred oversampling and a show-ahead receive FIFO
module uart_depacketizer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          serial_in,
    output logic [7:0]    data_out,
    output logic          data_out_valid,
    input  logic          data_ready,
    output logic          rx_busy,
    output logic          framing_error,
    output logic          overrun,
    output logic [CW-1:0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_END = TW'(CLKS_PER_BIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_nx;
    logic rx_m, rx_s;
    logic [TW-1:0] cnt, cnt_nx;
    logic [2:0] idx, idx_nx;
    logic [7:0] shift, shift_nx;
    logic stop_good, stop_bad;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic full, pop, push;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {rx_m, rx_s} <= 2'b11;
        else {rx_m, rx_s} <= {serial_in, rx_m};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shift <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            idx <= idx_nx;
            shift <= shift_nx;
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx = cnt + 1'b1;
        idx_nx = idx;
        shift_nx = shift;
        stop_good = 1'b0;
        stop_bad = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!rx_s) state_nx = START;
            end
            START: if (cnt == HALF_END) begin
                cnt_nx = '0;
                idx_nx = '0;
                state_nx = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == BIT_END) begin
                cnt_nx = '0;
                shift_nx[idx] = rx_s;
                idx_nx = idx + 3'd1;
                if (idx == 3'd7) state_nx = STOP;
            end
            STOP: if (cnt == BIT_END) begin
                cnt_nx = '0;
                state_nx = IDLE;
                stop_good = rx_s;
                stop_bad = !rx_s;
            end
        endcase
    end
    // a pop on the stop-sample cycle frees the slot the incoming byte needs
    assign full = fifo_count == CW'(FIFO_DEPTH);
    assign data_out_valid = fifo_count != '0;
    assign pop = data_out_valid & data_ready;
    assign push = stop_good & (!full | pop);
    assign data_out = data_out_valid ? mem[rd_ptr] : 8'h00;
    assign rx_busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shift;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            framing_error <= 1'b0;
            overrun <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            framing_error <= stop_bad;
            overrun <= stop_good & full & !pop;
        end
    end
endmodule

// File: tb/tb_uart_depacketizer.sv
// tb_uart_depacketizer: frame-level queue model of the UART receiver, directed cases plus random traffic
module tb_uart_depacketizer;
    localparam int CPB = 16;
    localparam int DEPTH = 8;
    logic clk = 1'b0, rst = 1'b0, serial_in = 1'b1, data_ready = 1'b0;
    logic [7:0] data_out;
    logic data_out_valid, rx_busy, framing_error, overrun;
    logic [3:0] fifo_count;
    int errors = 0, checks = 0, fe_cnt = 0, ov_cnt = 0;
    logic [7:0] q[$];

    always #10 clk = ~clk;

    uart_depacketizer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .data_out(data_out),
        .data_out_valid(data_out_valid), .data_ready(data_ready), .rx_busy(rx_busy),
        .framing_error(framing_error), .overrun(overrun), .fifo_count(fifo_count)
    );

    always @(negedge clk) begin
        fe_cnt += int'(framing_error);
        ov_cnt += int'(overrun);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // start bit, nbits data bits LSB first, then the stop bit when the frame is complete
    task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits);
        @(posedge clk);
        #1 serial_in = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            #1 serial_in = b[i];
            repeat (CPB) @(posedge clk);
        end
        if (nbits == 8) begin
            #1 serial_in = stop;
            repeat (CPB) @(posedge clk);
            #1 serial_in = 1'b1;
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop, input int gap);
        int fe0, ov0;
        logic exp_ov;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        exp_ov = stop && q.size() == DEPTH;
        send_frame(b, stop, 8);
        if (gap > 0) idle(gap);
        if (stop && !exp_ov) q.push_back(b);
        check("framing_error", 32'(fe_cnt - fe0), 32'(!stop));
        check("overrun", 32'(ov_cnt - ov0), 32'(exp_ov));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
    endtask

    task automatic pop_one(input string tag);
        check({tag, "_valid"}, 32'(data_out_valid), 32'd1);
        check({tag, "_data"}, 32'(data_out), 32'(q.size() != 0 ? q[0] : 8'h00));
        data_ready = 1'b1;
        @(posedge clk);
        #1 data_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        check({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
    endtask

    // full FIFO: pop lands exactly on the stop-sample edge (start edge + 3 + CPB/2 + 9*CPB)
    task automatic full_swap(input logic [7:0] b);
        int ov0, fe0;
        ov0 = ov_cnt;
        fe0 = fe_cnt;
        fork
            send_frame(b, 1'b1, 8);
            begin
                repeat (3 + CPB / 2 + 9 * CPB) @(posedge clk);
                #1 data_ready = 1'b1;
                check("swap_head", 32'(data_out), 32'(q[0]));
                @(posedge clk);
                #1 data_ready = 1'b0;
                check("swap_count", 32'(fifo_count), 32'(DEPTH));
            end
        join
        void'(q.pop_front());
        q.push_back(b);
        idle(2 * CPB);
        check("swap_overrun", 32'(ov_cnt - ov0), 32'd0);
        check("swap_ferr", 32'(fe_cnt - fe0), 32'd0);
        check("swap_count_after", 32'(fifo_count), 32'(q.size()));
    endtask

    initial begin
        int fe0, ov0;
        logic [7:0] ab;
        idle(3);
        rst = 1'b1;
        idle(4);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_valid", 32'(data_out_valid), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_flags", 32'(fe_cnt + ov_cnt), 32'd0);

        rx_frame(8'h55, 1'b1, 2 * CPB);
        check("t1_data", 32'(data_out), 32'h55);
        check("t1_valid", 32'(data_out_valid), 32'd1);
        pop_one("t1_pop");

        rx_frame(8'hAA, 1'b1, 0);
        rx_frame(8'h0F, 1'b1, 2 * CPB);
        pop_one("t2_pop_a");
        pop_one("t2_pop_b");
        check("t2_valid_drop", 32'(data_out_valid), 32'd0);

        fe0 = fe_cnt;
        ov0 = ov_cnt;
        serial_in = 1'b0;
        idle(4);
        serial_in = 1'b1;
        check("t3_busy_during", 32'(rx_busy), 32'd1);
        idle(24);
        check("t3_busy_after", 32'(rx_busy), 32'd0);
        check("t3_count", 32'(fifo_count), 32'd0);
        check("t3_flags", 32'(fe_cnt - fe0 + ov_cnt - ov0), 32'd0);

        rx_frame(8'h3C, 1'b0, 2 * CPB);

        for (int i = 1; i <= 9; i++) rx_frame(8'(i), 1'b1, 2 * CPB);
        full_swap(8'h5A);
        while (q.size() != 0) pop_one("t5_drain");
        check("t5_empty", 32'(data_out_valid), 32'd0);

        rx_frame(8'h77, 1'b1, 2 * CPB);
        ab = 8'hE1;
        send_frame(ab, 1'b1, 4);
        #1 serial_in = ab[4];
        repeat (CPB / 2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        q.delete();
        check("t6_rst_count", 32'(fifo_count), 32'd0);
        check("t6_rst_valid", 32'(data_out_valid), 32'd0);
        check("t6_rst_busy", 32'(rx_busy), 32'd0);
        check("t6_rst_data", 32'(data_out), 32'd0);
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(4);
        rx_frame(8'hC3, 1'b1, 2 * CPB);
        pop_one("t6_pop");
        check("t6_empty", 32'(data_out_valid), 32'd0);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                rx_frame(8'($urandom), $urandom_range(0, 7) != 0, 2 * CPB);
            end else if (q.size() == 0) begin
                data_ready = 1'b1;
                @(posedge clk);
                #1 data_ready = 1'b0;
                check("rnd_empty_count", 32'(fifo_count), 32'd0);
                check("rnd_empty_valid", 32'(data_out_valid), 32'd0);
            end else begin
                repeat ($urandom_range(1, q.size())) pop_one("rnd_pop");
            end
        end
        while (q.size() != 0) pop_one("final_drain");
        check("final_empty", 32'(data_out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
